// File: rtl/status_cond_unit.sv
// NZCV flag register with same-cycle forwarding and ARM condition-field evaluation.
// Flags are packed {Z, C, N, V} on every port and in the register.
module status_cond_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] status_in,
    input  logic       exe_valid,
    input  logic       exe_s,
    input  logic       exe_arith,
    input  logic       flush,
    input  logic       freeze,
    input  logic [3:0] id_cond,
    output logic       cond_pass,
    output logic       carry_out,
    output logic [3:0] status_out
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic [3:0] nxt;
    logic [3:0] eff;
    logic       wr_ok;
    logic       we;
    logic       z, c, n, v;

    assign wr_ok = exe_valid & exe_s & ~flush;
    assign we    = wr_ok & ~freeze;

    // Logical ops leave C and V alone; the ALU's zeros there must not land.
    assign nxt = exe_arith ? status_in : {status_in[3], flags_q[2], status_in[1], flags_q[0]};

    // ID stalls with EX, so forwarding does not look at freeze.
    assign eff = wr_ok ? nxt : flags_q;

    always_comb begin
        flags_d = flags_q;
        if (we) begin
            flags_d = nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else if (!freeze) begin
            flags_q <= flags_d;
        end
    end

    assign z = eff[3];
    assign c = eff[2];
    assign n = eff[1];
    assign v = eff[0];

    always_comb begin
        cond_pass = 1'b0;
        case (id_cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = ~c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = c & ~z;
            4'b1001: cond_pass = ~c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Carry for ADC/SBC comes from committed flags only.
    assign carry_out  = flags_q[2];
    assign status_out = flags_q;

endmodule
